// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among NUM_REQ requesters,
// issuing a one-cycle start, tracking the done level and recovering via a watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 8191
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic                       timeout_err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_done
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CLR, WAIT_DONE} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_nxt, rr_inc_c;
  logic [WD_W-1:0]     wd_cnt, wd_nxt;
  logic [NUM_REQ-1:0]  ack_nxt, done_nxt;
  logic                timeout_nxt, busy_nxt, tx_start_nxt;
  logic [ID_W-1:0]     grant_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic [ID_W-1:0]     pick_c;
  logic                pick_vld_c;
  logic                wd_expired_c;
  int unsigned         idx_c;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign rr_inc_c     = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
  assign wd_expired_c = (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_c     = '0;
    pick_vld_c = 1'b0;
    idx_c      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx_c = (32'(rr_ptr) + off) % NUM_REQ;
      if (!pick_vld_c && req[ID_W'(idx_c)]) begin
        pick_vld_c = 1'b1;
        pick_c     = ID_W'(idx_c);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      ack         <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      wd_cnt      <= wd_nxt;
      ack         <= ack_nxt;
      done        <= done_nxt;
      timeout_err <= timeout_nxt;
      busy        <= busy_nxt;
      grant_id    <= grant_nxt;
      tx_start    <= tx_start_nxt;
      tx_data     <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pick_vld_c) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_CLR;
      WAIT_CLR:  state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done || wd_expired_c) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // tx_done wins over a simultaneous watchdog expiry; tx_done is ignored in WAIT_CLR (stale level).
  always_comb begin
    ack_nxt      = '0;
    done_nxt     = '0;
    timeout_nxt  = 1'b0;
    tx_start_nxt = 1'b0;
    busy_nxt     = (state_nxt != IDLE);
    grant_nxt    = grant_id;
    data_nxt     = tx_data;
    rr_nxt       = rr_ptr;
    wd_nxt       = wd_cnt;
    case (state)
      IDLE: begin
        if (pick_vld_c) begin
          grant_nxt = pick_c;
          data_nxt  = data_arr[pick_c];
        end
      end
      ISSUE: begin
        tx_start_nxt      = 1'b1;
        ack_nxt[grant_id] = 1'b1;
        wd_nxt            = '0;
      end
      WAIT_CLR: wd_nxt = wd_cnt + WD_W'(1);
      WAIT_DONE: begin
        wd_nxt = wd_cnt + WD_W'(1);
        if (tx_done) begin
          done_nxt[grant_id] = 1'b1;
          rr_nxt             = rr_inc_c;
        end else if (wd_expired_c) begin
          timeout_nxt = 1'b1;
          rr_nxt      = rr_inc_c;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the bench plays the transmitter's tx_done.
module tb_uart_tx_arbiter;

  localparam int TO = 8191;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack, done;
  logic        timeout_err, busy, tx_start, tx_done;
  logic [1:0]  grant_id;
  logic [7:0]  tx_data;
  logic [7:0]  dat [4];

  int checks = 0;
  int errors = 0;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  uart_tx_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .timeout_err(timeout_err), .busy(busy),
    .grant_id(grant_id), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for tx_start, checks the grant, then completes the transfer after dly cycles.
  task automatic serve(input int id, input logic [7:0] d, input logic [3:0] req_after,
                       input int dly, input int exp_wait, input string nm);
    int  w;
    bit  bad;
    w = 0;
    while (!tx_start && w < 20) begin tick(); w++; end
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_start got no tx_start within %0d cycles", nm, w);
      return;
    end
    checks++;
    if (w !== exp_wait) begin errors++; $display("FAIL %s_latency got %0d exp %0d", nm, w, exp_wait); end
    checks++;
    if (ack !== 4'(1 << id)) begin errors++; $display("FAIL %s_ack got %b exp %b", nm, ack, 4'(1 << id)); end
    checks++;
    if (grant_id !== 2'(id)) begin errors++; $display("FAIL %s_grant got %0d exp %0d", nm, grant_id, id); end
    checks++;
    if (tx_data !== d) begin errors++; $display("FAIL %s_data got %h exp %h", nm, tx_data, d); end
    req = req_after;
    tick();
    checks++;
    if (done !== 4'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_stale done=%b busy=%b exp 0000/1", nm, done, busy);
    end
    tx_done = 1'b0;
    bad = 1'b0;
    repeat (dly) begin
      tick();
      if (done !== 4'b0 || timeout_err !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL %s_wait early done/err or busy drop got 1 exp 0", nm); end
    tx_done = 1'b1;
    tick();
    checks++;
    if (done !== 4'(1 << id) || busy !== 1'b0) begin
      errors++; $display("FAIL %s_done done=%b busy=%b exp %b/0", nm, done, busy, 4'(1 << id));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; tx_done = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    repeat (3) tick();
    checks++;
    if ({ack, done, timeout_err, busy, grant_id, tx_start, tx_data} !== 21'b0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {ack, done, timeout_err, busy, grant_id, tx_start, tx_data});
    end
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b tx_start=%b exp 0/0", busy, tx_start);
    end
  endtask

  task automatic test_single();
    dat[2] = 8'hA5; req = 4'b0100;
    tick();
    checks++;
    if (tx_start !== 1'b0 || ack !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd2 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_grant start=%b ack=%b busy=%b id=%0d data=%h exp 0/0000/1/2/a5",
               tx_start, ack, busy, grant_id, tx_data);
    end
    serve(2, 8'hA5, 4'b0000, 4350, 1, "single");
    tick();
    checks++;
    if (done !== 4'b0) begin errors++; $display("FAIL single_pulse done=%b exp 0000", done); end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1; tick(); reset = 1'b0; tx_done = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = 8'(8'h10 + i);
    req = 4'b1111;
    serve(0, 8'h10, 4'b1111, 3, 2, "b2b0");
    serve(1, 8'h11, 4'b1111, 3, 2, "b2b1");
    serve(2, 8'h12, 4'b1111, 3, 2, "b2b2");
    serve(3, 8'h13, 4'b1111, 3, 2, "b2b3");
    serve(0, 8'h10, 4'b0000, 3, 2, "b2b4");
  endtask

  task automatic test_stale();
    checks++;
    if (tx_done !== 1'b1) begin errors++; $display("FAIL stale_setup tx_done=%b exp 1", tx_done); end
    dat[2] = 8'hC3; req = 4'b0100;
    serve(2, 8'hC3, 4'b0000, 2, 2, "stale");
  endtask

  task automatic test_timeout();
    bit bad;
    dat[1] = 8'h77; req = 4'b0010;
    tick(); tick();
    checks++;
    if (tx_start !== 1'b1 || ack !== 4'b0010 || grant_id !== 2'd1) begin
      errors++; $display("FAIL to_grant start=%b ack=%b id=%0d exp 1/0010/1", tx_start, ack, grant_id);
    end
    req = 4'b0000;
    tick();
    tx_done = 1'b0;
    bad = 1'b0;
    repeat (TO - 2) begin
      tick();
      if (timeout_err !== 1'b0 || done !== 4'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL to_early timeout_err/done got 1 exp 0"); end
    tick();
    checks++;
    if (timeout_err !== 1'b1 || done !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL to_pulse err=%b done=%b busy=%b exp 1/0000/0", timeout_err, done, busy);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_width err=%b exp 0", timeout_err); end
    dat[2] = 8'h88; req = 4'b0110;
    serve(2, 8'h88, 4'b0000, 2, 2, "to_next");
  endtask

  task automatic test_reset_mid();
    bit bad;
    dat[0] = 8'h3C; req = 4'b0001;
    tick(); tick();
    checks++;
    if (tx_start !== 1'b1 || ack !== 4'b0001) begin
      errors++; $display("FAIL rm_grant start=%b ack=%b exp 1/0001", tx_start, ack);
    end
    req = 4'b0000;
    tick();
    tx_done = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ack, done, timeout_err, busy, grant_id, tx_start, tx_data} !== 21'b0) begin
      errors++; $display("FAIL rm_async got %h exp 0", {ack, done, timeout_err, busy, grant_id, tx_start, tx_data});
    end
    tick(); tick();
    reset = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (done !== 4'b0 || timeout_err !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rm_quiet done/err/busy got 1 exp 0"); end
    dat[1] = 8'h61; dat[3] = 8'h63; req = 4'b1010;
    tick();
    checks++;
    if (grant_id !== 2'd1) begin errors++; $display("FAIL rm_rrptr got %0d exp 1", grant_id); end
    serve(1, 8'h61, 4'b1000, 3, 1, "rm1");
    serve(3, 8'h63, 4'b0000, 3, 2, "rm3");
  endtask

  task automatic test_ignored();
    bit bad;
    dat[3] = 8'h5A; req = 4'b1000;
    tick(); tick();
    checks++;
    if (tx_start !== 1'b1 || ack !== 4'b1000 || tx_data !== 8'h5A) begin
      errors++; $display("FAIL ign_grant start=%b ack=%b data=%h exp 1/1000/5a", tx_start, ack, tx_data);
    end
    req = 4'b0010; dat[3] = 8'hFF;
    tick();
    req = 4'b0000; tx_done = 1'b0;
    repeat (3) tick();
    checks++;
    if (tx_data !== 8'h5A) begin errors++; $display("FAIL ign_data got %h exp 5a", tx_data); end
    tx_done = 1'b1;
    tick();
    checks++;
    if (done !== 4'b1000) begin errors++; $display("FAIL ign_done got %b exp 1000", done); end
    bad = 1'b0;
    repeat (6) begin
      tick();
      if (ack !== 4'b0 || busy !== 1'b0 || tx_start !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL ign_pulse dropped req[1] served got 1 exp 0"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stale();
    test_timeout();
    test_reset_mid();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
